ifu_fetch_ctrl: RTL
===================

Name: ifu_fetch_ctrl

Overview:
Instruction-fetch controller that sequences the combinational word-addressed instruction memory. It owns the fetch PC, drives the memory address, and captures returned words with their PC into a 2-entry buffer. It presents those words to decode over a valid/ready handshake. Decode/execute can redirect it on branch, jump or jr, and a misaligned redirect target traps it in a fault state.

Parameters:
PC_RESET, 32'h0000_3000, fetch PC value after reset
BUF_DEPTH, 2, instruction buffer entries (fixed at 2; other values are not supported)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous active-high reset
im_addr  out  32  address to instruction memory; equals fetch_pc combinationally
im_data  in  32  instruction word returned combinationally for im_addr
redirect_valid  in  1  taken branch/jump/jr this cycle
redirect_pc  in  32  new fetch target, valid when redirect_valid=1
inst_valid  out  1  buffer head holds an instruction for decode
inst  out  32  buffer head instruction word
inst_pc  out  32  PC of buffer head
inst_ready  in  1  decode accepts head this cycle
fault  out  1  sticky misaligned-redirect flag
fault_pc  out  32  offending redirect_pc, captured on entry to FAULT

Behaviour:
- Reset (async, any time, including mid-redirect or in FAULT): fetch_pc=PC_RESET, count=0, state=FETCH, fault=0, fault_pc=0, inst/inst_pc=0, inst_valid=0.
- States: FETCH, FAULT.
  - FETCH -> FAULT when redirect_valid=1 and redirect_pc[1:0]!=0.
  - FAULT exits only on reset.
- im_addr=fetch_pc at all times; in FAULT it holds the last value.
- inst_valid = (count!=0) & ~redirect_valid & (state==FETCH). inst and inst_pc always show the head entry.
- pop = inst_valid & inst_ready.
- push = (state==FETCH) & ~redirect_valid & ((count<2) | pop).
  - Push writes {fetch_pc, im_data} at the tail and sets fetch_pc <= fetch_pc+4.
  - Arithmetic is 32-bit with wrap at 32'hFFFF_FFFC -> 0.
- Simultaneous push and pop with count=2: the head advances and the new entry takes the freed slot; count stays 2.
- Latency: an instruction fetched in cycle N is visible at inst in cycle N+1. After reset, the first inst_valid=1 is the first cycle after reset deassertion plus one edge.
- Full: with count=2 and no pop, no push occurs; fetch_pc and im_addr hold.
- Empty: with count=0, inst_valid=0 and inst/inst_pc are don't-care but stable.
- Aligned redirect (redirect_pc[1:0]==0), in the cycle redirect_valid=1:
  - no push and no pop; inst_valid is forced 0;
  - next edge: count=0 and fetch_pc=redirect_pc.
  - Fetch resumes the following cycle, so the target instruction appears 2 edges after the redirect edge.
- Redirect has priority over inst_ready and over any push in the same cycle.
- Misaligned redirect:
  - flush the buffer;
  - capture fault_pc=redirect_pc and set fault=1;
  - enter FAULT. No further pushes; inst_valid stays 0.
- redirect_valid in FAULT is ignored.
- Back-to-back redirects: each cycle's redirect_pc overwrites fetch_pc; the last one wins.

Decomposition:
- Shared package: PC_RESET, state encodings (ST_FETCH, ST_FAULT), instruction word width 32, PC increment 4.
- Sub-module ifu_buf2: 2-entry FIFO holding 64-bit {pc,inst} entries.
  - Inputs: push, pop, flush, din.
  - Outputs: head, count.
  - Pointer wrap modulo 2.
- ifu_fetch_ctrl keeps the FSM, fetch_pc and the push/pop/redirect logic.

Test Plan:
1. Reset release, im model returns word=addr^32'hA5A5_0000, inst_ready=1 -> inst_pc sequence 3000, 3004, 3008 on consecutive cycles, with inst matching each pc.
2. inst_ready=0 for 5 cycles after reset -> count saturates at 2 and im_addr holds at 3008. Raising ready yields 3000, 3004, 3008, 300C with no gaps or duplicates.
3. Redirect to 32'h0000_3100 while count=2 and ready=1 -> inst_valid=0 in that cycle and both buffered entries are dropped. The next delivered inst_pc is 3100, 2 edges later.
4. Redirect to 32'h0000_3102 -> fault=1 and fault_pc=3102 from the next edge. inst_valid stays 0 and later redirects are ignored. Async reset clears fault and fetching restarts at 3000.
5. Redirect in two consecutive cycles (3200 then 3300) -> first delivered inst_pc is 3300. Nothing from 3200 is ever delivered.
6. Assert reset asynchronously mid-cycle during a redirect with count=1 -> outputs reset immediately without waiting for a clock edge. After release, the first inst_pc is 3000.

Source files
------------

// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller and its buffer.
package ifu_fetch_ctrl_pkg;

  localparam int          INST_W       = 32;
  localparam int          BUF_DEPTH    = 2;
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam logic [31:0] PC_INC       = 32'd4;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_FAULT = 1'b1
  } ifu_state_e;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } ibuf_entry_t;

  function automatic logic is_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_buf2.sv
// Two-entry FIFO of {pc, inst} pairs; head is always the oldest entry.
module ifu_buf2
  import ifu_fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  ibuf_entry_t din,
  output ibuf_entry_t head,
  output logic [1:0]  count
);

  ibuf_entry_t mem_q [BUF_DEPTH];
  logic        rd_ptr_q;
  logic        wr_ptr_q;
  logic [1:0]  count_q;

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  // Flush only rewinds pointers; stored words stay put so head remains stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch controller: owns fetch PC, fills the 2-entry buffer from imem, handles redirects.
// state    | meaning
// ST_FETCH | fetching sequentially, redirects accepted
// ST_FAULT | misaligned redirect seen; frozen until reset
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fault,
  output logic [31:0] fault_pc
);

  ifu_state_e  state_q;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        fault_q;
  logic [31:0] fault_pc_q;

  logic        redirect_act;
  logic        redirect_bad;
  logic        buf_push;
  logic        buf_pop;
  logic        buf_full;
  logic [1:0]  buf_count;
  ibuf_entry_t buf_din;
  ibuf_entry_t buf_head;

  assign redirect_act = redirect_valid & (state_q == ST_FETCH);
  assign redirect_bad = redirect_act & is_misaligned(redirect_pc);

  assign buf_full   = (buf_count == 2'(BUF_DEPTH));
  assign inst_valid = (buf_count != 2'd0) & ~redirect_valid & (state_q == ST_FETCH);
  assign buf_pop    = inst_valid & inst_ready;
  assign buf_push   = (state_q == ST_FETCH) & ~redirect_valid & (~buf_full | buf_pop);

  assign buf_din.pc   = fetch_pc_q;
  assign buf_din.inst = im_data;

  ifu_buf2 u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (buf_push),
    .pop   (buf_pop),
    .flush (redirect_act),
    .din   (buf_din),
    .head  (buf_head),
    .count (buf_count)
  );

  // A misaligned target is never loaded, so im_addr keeps its last value in FAULT.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_act && !redirect_bad) fetch_pc_d = redirect_pc;
    else if (buf_push)                 fetch_pc_d = fetch_pc_q + PC_INC;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= PC_RESET;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      case (state_q)
        ST_FETCH: begin
          if (redirect_bad) begin
            state_q    <= ST_FAULT;
            fault_q    <= 1'b1;
            fault_pc_q <= redirect_pc;
          end
        end
        ST_FAULT: state_q <= ST_FAULT;
        default:  state_q <= ST_FETCH;
      endcase
    end
  end

  assign im_addr  = fetch_pc_q;
  assign inst     = buf_head.inst;
  assign inst_pc  = buf_head.pc;
  assign fault    = fault_q;
  assign fault_pc = fault_pc_q;

endmodule
